// File: rtl/tail_light_seq.sv
// rtl/tail_light_seq.sv - sequential tail-light FSM with prescaled step strobe (optional TAIL_BRAKE_EN brake overlay)
module tail_light_seq #(
  parameter int unsigned STEP_DIV = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clock_en,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
`ifdef TAIL_BRAKE_EN
  input  logic       brake,
`endif
  output logic [2:0] lights_l,
  output logic [2:0] lights_r,
  output logic       active
);

  typedef enum logic [2:0] {IDLE, L1, L2, L3, R1, R2, R3, HAZ} state_t;

  localparam logic [7:0] LAST = 8'(STEP_DIV - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] step_cnt;
  logic       tick;
  logic [2:0] lights_l_next;
  logic [2:0] lights_r_next;
  logic       active_next;

  // inputs are only looked at on the last strobe of each prescaler period
  assign tick = clock_en && (step_cnt == LAST);

  // prescaler: counts divider strobes, wraps after STEP_DIV of them
  always_ff @(posedge clock) begin
    if (reset) begin
      step_cnt <= 8'd0;
    end else if (clock_en) begin
      step_cnt <= (step_cnt == LAST) ? 8'd0 : step_cnt + 8'd1;
    end
  end

  // state and lamp registers; lamps load the decode of the next state so they track the state with no lag
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      lights_l <= 3'b000;
      lights_r <= 3'b000;
      active   <= 1'b0;
    end else begin
      state    <= state_next;
      lights_l <= lights_l_next;
      lights_r <= lights_r_next;
      active   <= active_next;
    end
  end

  // next-state logic: advance only on tick, hazard preempts any running sequence
  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        IDLE: begin
          if (hazard || (left && right)) state_next = HAZ;
          else if (left)                 state_next = L1;
          else if (right)                state_next = R1;
          else                           state_next = IDLE;
        end
        L1:      state_next = hazard ? HAZ : L2;
        L2:      state_next = hazard ? HAZ : L3;
        L3:      state_next = hazard ? HAZ : IDLE;
        R1:      state_next = hazard ? HAZ : R2;
        R2:      state_next = hazard ? HAZ : R3;
        R3:      state_next = hazard ? HAZ : IDLE;
        HAZ:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // lamp decode of the next state, with the brake overlay lighting every side not running a sequence
  always_comb begin
    lights_l_next = 3'b000;
    lights_r_next = 3'b000;
    case (state_next)
      L1:      lights_l_next = 3'b001;
      L2:      lights_l_next = 3'b011;
      L3:      lights_l_next = 3'b111;
      R1:      lights_r_next = 3'b001;
      R2:      lights_r_next = 3'b011;
      R3:      lights_r_next = 3'b111;
      HAZ: begin
        lights_l_next = 3'b111;
        lights_r_next = 3'b111;
      end
      default: begin
        lights_l_next = 3'b000;
        lights_r_next = 3'b000;
      end
    endcase
    active_next = (state_next != IDLE);
`ifdef TAIL_BRAKE_EN
    if (brake) begin
      if (!(state_next == L1 || state_next == L2 || state_next == L3)) lights_l_next = 3'b111;
      if (!(state_next == R1 || state_next == R2 || state_next == R3)) lights_r_next = 3'b111;
    end
`endif
  end

endmodule

// File: tb/tb_tail_light_seq.sv
// tb/tb_tail_light_seq.sv - directed and random checks of tail_light_seq at STEP_DIV 1 and 3 against a behavioural model
module tb_tail_light_seq;

  logic       clock = 1'b0;
  logic       rst;
  logic       ce [2];
  logic       lf [2];
  logic       rt [2];
  logic       hz [2];
  logic       bk [2];
  logic [2:0] ll [2];
  logic [2:0] lr [2];
  logic       act [2];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // behavioural model: mode 0 idle, 1 left run, 2 right run, 3 hazard flash; pos = lamps lit in the run
  int div    [2] = '{1, 3};
  int m_mode [2];
  int m_pos  [2];
  int m_cnt  [2];
  int m_brk  [2];

  always #5 clock = ~clock;

  tail_light_seq #(.STEP_DIV(1)) u_a (
    .clock(clock), .reset(rst), .clock_en(ce[0]),
    .left(lf[0]), .right(rt[0]), .hazard(hz[0]),
`ifdef TAIL_BRAKE_EN
    .brake(bk[0]),
`endif
    .lights_l(ll[0]), .lights_r(lr[0]), .active(act[0])
  );

  tail_light_seq #(.STEP_DIV(3)) u_b (
    .clock(clock), .reset(rst), .clock_en(ce[1]),
    .left(lf[1]), .right(rt[1]), .hazard(hz[1]),
`ifdef TAIL_BRAKE_EN
    .brake(bk[1]),
`endif
    .lights_l(ll[1]), .lights_r(lr[1]), .active(act[1])
  );

  task automatic chk(input string tag, input int idx, input logic [2:0] obs, input logic [2:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%b expected=%b t=%0t", tag, idx, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_l(input int i);
    int v;
    v = (m_mode[i] == 3) ? 7 : (m_mode[i] == 1) ? ((1 << m_pos[i]) - 1) : 0;
    if (m_brk[i] != 0 && m_mode[i] != 1) v = 7;
    return 3'(v);
  endfunction

  function automatic logic [2:0] exp_r(input int i);
    int v;
    v = (m_mode[i] == 3) ? 7 : (m_mode[i] == 2) ? ((1 << m_pos[i]) - 1) : 0;
    if (m_brk[i] != 0 && m_mode[i] != 2) v = 7;
    return 3'(v);
  endfunction

  task automatic model_step(input int i, input logic r, input logic c, input logic l,
                            input logic rr, input logic h, input logic b);
    bit tk;
    if (r) begin
      m_mode[i] = 0; m_pos[i] = 0; m_cnt[i] = 0; m_brk[i] = 0;
    end else begin
      tk = c && (m_cnt[i] == div[i] - 1);
      if (c) m_cnt[i] = (m_cnt[i] + 1) % div[i];
      if (tk) begin
        case (m_mode[i])
          0: begin
            if (h || (l && rr))  m_mode[i] = 3;
            else if (l)          begin m_mode[i] = 1; m_pos[i] = 1; end
            else if (rr)         begin m_mode[i] = 2; m_pos[i] = 1; end
          end
          1, 2: begin
            if (h)                 m_mode[i] = 3;
            else if (m_pos[i] == 3) m_mode[i] = 0;
            else                   m_pos[i]++;
          end
          default: m_mode[i] = 0;
        endcase
      end
      m_brk[i] = b ? 1 : 0;
    end
  endtask

  // one clock: capture the inputs in force, let the edge pass, step the model and compare both instances
  task automatic cycle();
    logic r_c;
    logic c_c [2];
    logic l_c [2];
    logic r2_c [2];
    logic h_c [2];
    logic b_c [2];
    r_c = rst;
    for (int i = 0; i < 2; i++) begin
      c_c[i] = ce[i]; l_c[i] = lf[i]; r2_c[i] = rt[i]; h_c[i] = hz[i]; b_c[i] = bk[i];
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      model_step(i, r_c, c_c[i], l_c[i], r2_c[i], h_c[i], b_c[i]);
      chk("model_lights_l", i, ll[i], exp_l(i));
      chk("model_lights_r", i, lr[i], exp_r(i));
      chk("model_active", i, {2'b00, act[i]}, {2'b00, m_mode[i] != 0});
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      ce[i] = 1'b0; lf[i] = 1'b0; rt[i] = 1'b0; hz[i] = 1'b0; bk[i] = 1'b0;
    end
  endtask

  initial begin
    int act_cnt;
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_pos[i] = 0; m_cnt[i] = 0; m_brk[i] = 0;
    end
    clear_inputs();

    // reset with clock_en high, then idle hold
    rst = 1'b1; ce[0] = 1'b1; ce[1] = 1'b1;
    cycle(); cycle();
    chk("reset_lights_l", 0, ll[0], 3'b000);
    chk("reset_lights_r", 1, lr[1], 3'b000);
    chk("reset_active", 0, {2'b00, act[0]}, 3'b000);
    rst = 1'b0; clear_inputs();
    for (int j = 0; j < 10; j++) cycle();
    chk("idle_hold_l", 0, ll[0], 3'b000);
    chk("idle_hold_act", 1, {2'b00, act[1]}, 3'b000);

    // left sequence at STEP_DIV=1 with clock_en held
    ce[0] = 1'b1; lf[0] = 1'b1;
    cycle();
    act_cnt = int'(act[0]);
    chk("left_seq1", 0, ll[0], 3'b001);
    lf[0] = 1'b0;
    cycle(); act_cnt += int'(act[0]); chk("left_seq2", 0, ll[0], 3'b011);
    cycle(); act_cnt += int'(act[0]); chk("left_seq3", 0, ll[0], 3'b111);
    chk("left_seq3_r", 0, lr[0], 3'b000);
    cycle(); act_cnt += int'(act[0]); chk("left_seq4", 0, ll[0], 3'b000);
    chk("left_active_cycles", 0, 3'(act_cnt), 3'd3);

    // prescale: STEP_DIV=3, clock_en every 5 cycles, right held
    clear_inputs();
    rt[1] = 1'b1;
    for (int j = 0; j < 75; j++) begin
      ce[1] = (j % 5 == 4);
      cycle();
      if (j == 13) chk("presc_before_tick", 1, lr[1], 3'b000);
      if (j == 14) chk("presc_step1", 1, lr[1], 3'b001);
      if (j == 28) chk("presc_hold", 1, lr[1], 3'b001);
      if (j == 29) chk("presc_step2", 1, lr[1], 3'b011);
      if (j == 44) chk("presc_step3", 1, lr[1], 3'b111);
      if (j == 59) chk("presc_step4", 1, lr[1], 3'b000);
      if (j == 74) chk("presc_repeat", 1, lr[1], 3'b001);
    end
    clear_inputs();

    // hazard preempts a right sequence at R2, then flashes while held
    ce[0] = 1'b1; rt[0] = 1'b1;
    cycle();
    rt[0] = 1'b0;
    cycle(); chk("preempt_r2", 0, lr[0], 3'b011);
    hz[0] = 1'b1;
    cycle(); chk("preempt_haz_l", 0, ll[0], 3'b111); chk("preempt_haz_r", 0, lr[0], 3'b111);
    cycle(); chk("haz_off", 0, ll[0], 3'b000);
    cycle(); chk("haz_flash_on", 0, lr[0], 3'b111);
    cycle(); chk("haz_flash_off", 0, lr[0], 3'b000);
    hz[0] = 1'b0;

    // simultaneous left and right goes to hazard
    lf[0] = 1'b1; rt[0] = 1'b1;
    cycle(); chk("both_haz_l", 0, ll[0], 3'b111); chk("both_haz_r", 0, lr[0], 3'b111);
    lf[0] = 1'b0; rt[0] = 1'b0;
    cycle(); chk("both_idle", 0, {2'b00, act[0]}, 3'b000);

    // toggling a request between ticks does nothing
    ce[0] = 1'b0;
    lf[0] = 1'b1; cycle();
    lf[0] = 1'b0; cycle();
    lf[0] = 1'b1; cycle();
    lf[0] = 1'b0; ce[0] = 1'b1; cycle();
    chk("glitch_ignored", 0, {2'b00, act[0]}, 3'b000);

    // randomized traffic on both instances
    for (int j = 0; j < 400; j++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < 2; i++) begin
        ce[i] = ($urandom_range(0, 1) == 1);
        lf[i] = ($urandom_range(0, 2) == 0);
        rt[i] = ($urandom_range(0, 2) == 0);
        hz[i] = ($urandom_range(0, 7) == 0);
`ifdef TAIL_BRAKE_EN
        bk[i] = ($urandom_range(0, 3) == 0);
`endif
      end
      cycle();
    end
    rst = 1'b0; clear_inputs();

`ifdef TAIL_BRAKE_EN
    // brake during L2 on the prescaled instance, then brake in IDLE
    rst = 1'b1; cycle(); rst = 1'b0;
    ce[1] = 1'b1; lf[1] = 1'b1;
    cycle(); cycle(); cycle();
    lf[1] = 1'b0;
    cycle(); cycle(); cycle();
    ce[1] = 1'b0;
    chk("brake_pre_l2", 1, ll[1], 3'b011);
    bk[1] = 1'b1;
    cycle(); chk("brake_l2_l", 1, ll[1], 3'b011); chk("brake_l2_r", 1, lr[1], 3'b111);
    bk[1] = 1'b0;
    cycle(); chk("brake_release_r", 1, lr[1], 3'b000);
    rst = 1'b1; cycle(); rst = 1'b0;
    bk[1] = 1'b1;
    cycle(); chk("brake_idle_l", 1, ll[1], 3'b111); chk("brake_idle_r", 1, lr[1], 3'b111);
    bk[1] = 1'b0;
    cycle(); chk("brake_idle_off_l", 1, ll[1], 3'b000); chk("brake_idle_off_r", 1, lr[1], 3'b000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
